// File: rtl/mem_port_arbiter4_if.sv
// Handshake bundle between the four requesters, the shared memory port and the arbiter.
// The master modport is the arbiter's view; slave is the requester/resource side.
interface mem_port_arbiter4_if;
   logic [3:0] req;
   logic       mem_ready;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       mem_valid;
   logic [3:0] done;
   logic       timeout_err;
   logic       busy;

   modport master (
      input  req,
      input  mem_ready,
      output sel,
      output gnt,
      output mem_valid,
      output done,
      output timeout_err,
      output busy
   );

   modport slave (
      output req,
      output mem_ready,
      input  sel,
      input  gnt,
      input  mem_valid,
      input  done,
      input  timeout_err,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter/sequencer sharing one 32-bit memory port among four requesters,
// with one-hot grant, completion pulse and abort of stalled transfers.
module mem_port_arbiter4 #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   mem_port_arbiter4_if.master  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [1:0]       ptr;
   logic [1:0]       idx;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       winner;
   logic [1:0]       cand;
   logic             timeout_hit;

   // Walk from the highest rotated offset down so the nearest set bit at or after ptr wins.
   always_comb begin
      winner = ptr;
      cand   = ptr;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr + 2'(i);
         if (bus.req[cand]) begin
            winner = cand;
         end
      end
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         ptr             <= 2'd0;
         idx             <= 2'd0;
         cnt             <= '0;
         bus.sel         <= 2'd0;
         bus.gnt         <= 4'b0;
         bus.mem_valid   <= 1'b0;
         bus.done        <= 4'b0;
         bus.timeout_err <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         bus.done        <= 4'b0;
         bus.timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req != 4'b0) begin
                  state         <= GRANT;
                  idx           <= winner;
                  bus.sel       <= winner;
                  bus.gnt       <= 4'b0001 << winner;
                  bus.mem_valid <= 1'b1;
                  bus.busy      <= 1'b1;
                  cnt           <= '0;
               end
            end
            GRANT: begin
               // A ready in the same cycle as the timeout is a normal completion.
               if (bus.mem_ready || timeout_hit) begin
                  state           <= DONE;
                  bus.gnt         <= 4'b0;
                  bus.mem_valid   <= 1'b0;
                  bus.done        <= 4'b0001 << idx;
                  bus.timeout_err <= !bus.mem_ready;
                  ptr             <= idx + 2'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               bus.gnt       <= 4'b0;
               bus.mem_valid <= 1'b0;
               bus.busy      <= 1'b0;
            end
         endcase
      end
   end

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.gnt));
   a_gnt_valid: assert property (@(posedge clk) disable iff (!rst_n)
      ((bus.gnt != 4'b0) == bus.mem_valid));
   a_sel_match: assert property (@(posedge clk) disable iff (!rst_n)
      ((bus.gnt != 4'b0) |-> (bus.gnt == (4'b0001 << bus.sel))));
   a_done_gnt: assert property (@(posedge clk) disable iff (!rst_n)
      !((bus.done != 4'b0) && (bus.gnt != 4'b0)));

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Directed bench for mem_port_arbiter4: a transfer-level model checked every cycle,
// plus hand-computed expectations for reset, single transfer, round-robin and timeouts.
module tb_mem_port_arbiter4;

   localparam int TIMEOUT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter4_if bus ();

   mem_port_arbiter4 #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Transfer-level model: phase 0 waiting, 1 transfer running, 2 completion slot.
   int m_phase = 0;
   int m_owner = 0;
   int m_ptr   = 0;
   int m_age   = 0;
   int m_sel   = 0;
   bit m_abort = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_owner = 0;
         m_ptr   = 0;
         m_age   = 0;
         m_sel   = 0;
         m_abort = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               if (bus.req != 4'b0) begin
                  for (int k = 3; k >= 0; k--) begin
                     if (bus.req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                  end
                  m_sel   = m_owner;
                  m_age   = 1;
                  m_phase = 1;
               end
            end
            1: begin
               if (bus.mem_ready) begin
                  m_phase = 2;
                  m_abort = 1'b0;
                  m_ptr   = (m_owner + 1) % 4;
               end else if (TIMEOUT != 0 && m_age == TIMEOUT) begin
                  m_phase = 2;
                  m_abort = 1'b1;
                  m_ptr   = (m_owner + 1) % 4;
               end else begin
                  m_age = m_age + 1;
               end
            end
            default: begin
               m_phase = 0;
               m_abort = 1'b0;
            end
         endcase
      end
   end

   function automatic logic [3:0] modelGnt();
      return (m_phase == 1) ? 4'(1 << m_owner) : 4'b0;
   endfunction

   function automatic logic [3:0] modelDone();
      return (m_phase == 2) ? 4'(1 << m_owner) : 4'b0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Every cycle, just after the edge, hold the DUT against the model.
   always @(posedge clk) begin
      #1;
      checkOutput("model_gnt",       32'(bus.gnt),         32'(modelGnt()));
      checkOutput("model_sel",       32'(bus.sel),         32'(m_sel));
      checkOutput("model_mem_valid", 32'(bus.mem_valid),   32'(m_phase == 1));
      checkOutput("model_done",      32'(bus.done),        32'(modelDone()));
      checkOutput("model_timeout",   32'(bus.timeout_err), 32'(m_phase == 2 && m_abort));
      checkOutput("model_busy",      32'(bus.busy),        32'(m_phase != 0));
   end

   task automatic applyStimulus(input logic [3:0] r, input logic m);
      @(negedge clk);
      bus.req       = r;
      bus.mem_ready = m;
      @(posedge clk);
      #1;
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, "_sel"},       32'(bus.sel),         32'h0);
      checkOutput({tag, "_gnt"},       32'(bus.gnt),         32'h0);
      checkOutput({tag, "_mem_valid"}, 32'(bus.mem_valid),   32'h0);
      checkOutput({tag, "_done"},      32'(bus.done),        32'h0);
      checkOutput({tag, "_timeout"},   32'(bus.timeout_err), 32'h0);
      checkOutput({tag, "_busy"},      32'(bus.busy),        32'h0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = 4'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] simulation hung");
   end

   int rrIdx[$];
   int rrCyc[$];
   int rrOrder[5] = '{0, 1, 2, 3, 0};
   int validCycles;
   int bound;
   int gi;

   initial begin
      bus.req       = 4'b0;
      bus.mem_ready = 1'b0;

      // Reset held with random inputs.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'($urandom), 1'($urandom));
         checkCleared("reset_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester, ready on the third grant cycle.
      doReset();
      applyStimulus(4'b0100, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         checkOutput("single_gnt",   32'(bus.gnt),       32'h4);
         checkOutput("single_sel",   32'(bus.sel),       32'h2);
         checkOutput("single_valid", 32'(bus.mem_valid), 32'h1);
         applyStimulus(4'b0100, (c == 3));
      end
      checkOutput("single_done",      32'(bus.done),      32'h4);
      checkOutput("single_done_gnt",  32'(bus.gnt),       32'h0);
      checkOutput("single_done_busy", 32'(bus.busy),      32'h1);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("single_idle_busy", 32'(bus.busy),      32'h0);
      checkOutput("single_idle_done", 32'(bus.done),      32'h0);
      checkOutput("single_idle_sel",  32'(bus.sel),       32'h2);

      // Round-robin with all four requesting; ready held high even outside grants.
      doReset();
      for (int i = 0; i < 14; i++) begin
         applyStimulus(4'b1111 & ~modelDone(), 1'b1);
         if (bus.gnt != 4'b0) begin
            gi = -1;
            for (int b = 0; b < 4; b++) begin
               if (bus.gnt == 4'(1 << b)) gi = b;
            end
            rrIdx.push_back(gi);
            rrCyc.push_back(i + 1);
         end
      end
      checkOutput("rr_count", 32'(rrIdx.size()), 32'd5);
      if (rrCyc.size() > 0) checkOutput("rr_first_cycle", 32'(rrCyc[0]), 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k < rrIdx.size()) begin
            checkOutput("rr_order", 32'(rrIdx[k]), 32'(rrOrder[k]));
            if (k > 0) checkOutput("rr_spacing", 32'(rrCyc[k] - rrCyc[k-1]), 32'd3);
         end
      end
      bus.mem_ready = 1'b0;

      // Timeout abort on requester 1.
      doReset();
      applyStimulus(4'b0010, 1'b0);
      validCycles = 0;
      bound = 0;
      while (bus.mem_valid && bound < 40) begin
         validCycles++;
         bound++;
         applyStimulus(4'b0010, 1'b0);
      end
      checkOutput("to_valid_cycles", 32'(validCycles),     32'd16);
      checkOutput("to_done",         32'(bus.done),        32'h2);
      checkOutput("to_err",          32'(bus.timeout_err), 32'h1);
      checkOutput("to_busy",         32'(bus.busy),        32'h1);
      applyStimulus(4'b0000, 1'b0);
      checkOutput("to_err_clear",    32'(bus.timeout_err), 32'h0);
      checkOutput("to_idle_sel",     32'(bus.sel),         32'h1);
      applyStimulus(4'b0111, 1'b0);
      checkOutput("to_next_gnt",     32'(bus.gnt),         32'h4);
      checkOutput("to_next_sel",     32'(bus.sel),         32'h2);
      applyStimulus(4'b0111, 1'b1);
      checkOutput("to_next_done",    32'(bus.done),        32'h4);
      checkOutput("to_next_err",     32'(bus.timeout_err), 32'h0);

      // Ready arrives on the 16th grant cycle: normal completion wins.
      doReset();
      applyStimulus(4'b0010, 1'b0);
      repeat (15) applyStimulus(4'b0010, 1'b0);
      checkOutput("coll_valid16", 32'(bus.mem_valid),   32'h1);
      applyStimulus(4'b0010, 1'b1);
      checkOutput("coll_done",    32'(bus.done),        32'h2);
      checkOutput("coll_err",     32'(bus.timeout_err), 32'h0);
      applyStimulus(4'b0000, 1'b0);

      // Reset asserted mid-transfer, between clock edges.
      doReset();
      applyStimulus(4'b0100, 1'b0);
      applyStimulus(4'b0100, 1'b0);
      checkOutput("mid_pre_gnt", 32'(bus.gnt), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      checkCleared("mid_async");
      applyStimulus(4'($urandom), 1'($urandom));
      checkCleared("mid_hold");
      @(negedge clk);
      rst_n = 1'b1;
      bus.req = 4'b1000;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mid_new_gnt",  32'(bus.gnt),  32'h8);
      checkOutput("mid_new_sel",  32'(bus.sel),  32'h3);
      checkOutput("mid_new_done", 32'(bus.done), 32'h0);
      applyStimulus(4'b1000, 1'b1);
      checkOutput("mid_new_complete", 32'(bus.done), 32'h8);
      applyStimulus(4'b0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
